// File: rtl/ascon_pack.sv
// Shared types and round constants for the Ascon
// encryption controller.
package ascon_pack;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } state_t;

  localparam logic [3:0] PA_FIRST_ROUND = 4'd0;
  localparam logic [3:0] PB_FIRST_ROUND = 4'd6;
  localparam logic [3:0] LAST_ROUND     = 4'd11;

  // An empty plaintext still carries one padding block.
  function automatic logic [3:0] norm_pt(
    input logic [3:0] n
  );
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/round_counter.sv
// Loadable 4-bit permutation round counter; load
// wins over enable.
module round_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] value,
  output logic [3:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= value;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_ctrl.sv
// Ascon-128 encryption control FSM: sequences the
// init, AD, PT and finalization permutations.
module ascon_ctrl
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] ad_blocks_i,
  input  logic [3:0] pt_blocks_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic       enable_o,
  output logic       xor_data_begin_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_ext_end_o,
  output logic       enable_cipher_o,
  output logic       enable_tag_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       cipher_valid_o,
  output logic       done_o
);

  state_t     state;
  state_t     state_next;
  logic [3:0] ad_cnt;
  logic [3:0] pt_cnt;
  logic       rc_load;
  logic       rc_inc;
  logic [3:0] rc_value;
  logic       cnt_load;
  logic       ad_dec;
  logic       pt_dec;
  logic       pt_last;
  logic [3:0] pt_entry;
  logic [3:0] pt_next_entry;
  logic       at_last;
  logic       cv_q;
  logic       done_q;

  round_counter u_round (
    .clk   (clock_i),
    .rst   (reset_i),
    .load  (rc_load),
    .en    (rc_inc),
    .value (rc_value),
    .count (round_o)
  );

  assign pt_last = (pt_cnt <= 4'd1);
  assign at_last = (round_o == LAST_ROUND);

  // The final PT block is absorbed at round 0 so that
  // it flows straight into the 12-round finalization.
  assign pt_entry =
    pt_last ? PA_FIRST_ROUND : PB_FIRST_ROUND;
  assign pt_next_entry =
    (pt_cnt <= 4'd2) ? PA_FIRST_ROUND
                     : PB_FIRST_ROUND;

  always_comb begin
    state_next       = state;
    rc_load          = 1'b0;
    rc_inc           = 1'b0;
    rc_value         = PA_FIRST_ROUND;
    cnt_load         = 1'b0;
    ad_dec           = 1'b0;
    pt_dec           = 1'b0;
    data_ready_o     = 1'b0;
    select_o         = 1'b0;
    enable_o         = 1'b0;
    xor_data_begin_o = 1'b0;
    xor_key_begin_o  = 1'b0;
    xor_key_end_o    = 1'b0;
    xor_ext_end_o    = 1'b0;
    enable_cipher_o  = 1'b0;
    enable_tag_o     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_INIT;
          rc_load    = 1'b1;
          rc_value   = PA_FIRST_ROUND;
          cnt_load   = 1'b1;
        end
      end
      ST_INIT: begin
        enable_o = 1'b1;
        select_o = (round_o == PA_FIRST_ROUND);
        if (at_last) begin
          xor_key_end_o = 1'b1;
          rc_load       = 1'b1;
          if (ad_cnt == 4'd0) begin
            xor_ext_end_o = 1'b1;
            state_next    = ST_PT;
            rc_value      = pt_entry;
          end else begin
            state_next = ST_AD;
            rc_value   = PB_FIRST_ROUND;
          end
        end else begin
          rc_inc = 1'b1;
        end
      end
      ST_AD: begin
        if (round_o == PB_FIRST_ROUND) begin
          data_ready_o     = 1'b1;
          enable_o         = data_valid_i;
          xor_data_begin_o = data_valid_i;
          rc_inc           = data_valid_i;
        end else if (at_last) begin
          enable_o = 1'b1;
          rc_load  = 1'b1;
          if (ad_cnt <= 4'd1) begin
            xor_ext_end_o = 1'b1;
            state_next    = ST_PT;
            rc_value      = pt_entry;
          end else begin
            ad_dec   = 1'b1;
            rc_value = PB_FIRST_ROUND;
          end
        end else begin
          enable_o = 1'b1;
          rc_inc   = 1'b1;
        end
      end
      ST_PT: begin
        if (pt_last) begin
          data_ready_o     = 1'b1;
          enable_o         = data_valid_i;
          xor_data_begin_o = data_valid_i;
          xor_key_begin_o  = data_valid_i;
          enable_cipher_o  = data_valid_i;
          rc_inc           = data_valid_i;
          if (data_valid_i) begin
            state_next = ST_FINAL;
          end
        end else if (round_o == PB_FIRST_ROUND) begin
          data_ready_o     = 1'b1;
          enable_o         = data_valid_i;
          xor_data_begin_o = data_valid_i;
          enable_cipher_o  = data_valid_i;
          rc_inc           = data_valid_i;
        end else if (at_last) begin
          enable_o = 1'b1;
          pt_dec   = 1'b1;
          rc_load  = 1'b1;
          rc_value = pt_next_entry;
        end else begin
          enable_o = 1'b1;
          rc_inc   = 1'b1;
        end
      end
      ST_FINAL: begin
        enable_o = 1'b1;
        if (at_last) begin
          xor_key_end_o = 1'b1;
          enable_tag_o  = 1'b1;
          state_next    = ST_DONE;
          rc_load       = 1'b1;
          rc_value      = PA_FIRST_ROUND;
        end else begin
          rc_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state  <= ST_IDLE;
      ad_cnt <= 4'd0;
      pt_cnt <= 4'd0;
      cv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cv_q   <= enable_cipher_o;
      done_q <= enable_tag_o;
      if (cnt_load) begin
        ad_cnt <= ad_blocks_i;
        pt_cnt <= norm_pt(pt_blocks_i);
      end else begin
        if (ad_dec && ad_cnt != 4'd0) begin
          ad_cnt <= ad_cnt - 4'd1;
        end
        if (pt_dec && pt_cnt > 4'd1) begin
          pt_cnt <= pt_cnt - 4'd1;
        end
      end
    end
  end

  assign busy_o         = (state != ST_IDLE);
  assign cipher_valid_o = cv_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_ascon_ctrl.sv
// Self-checking bench for ascon_ctrl: a scripted
// schedule of expected outputs per cycle.
module tb_ascon_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [3:0] ad_blocks_i;
  logic [3:0] pt_blocks_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic       select_o;
  logic       enable_o;
  logic       xor_data_begin_o;
  logic       xor_key_begin_o;
  logic       xor_key_end_o;
  logic       xor_ext_end_o;
  logic       enable_cipher_o;
  logic       enable_tag_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       cipher_valid_o;
  logic       done_o;

  ascon_ctrl dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .ad_blocks_i      (ad_blocks_i),
    .pt_blocks_i      (pt_blocks_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .select_o         (select_o),
    .enable_o         (enable_o),
    .xor_data_begin_o (xor_data_begin_o),
    .xor_key_begin_o  (xor_key_begin_o),
    .xor_key_end_o    (xor_key_end_o),
    .xor_ext_end_o    (xor_ext_end_o),
    .enable_cipher_o  (enable_cipher_o),
    .enable_tag_o     (enable_tag_o),
    .round_o          (round_o),
    .busy_o           (busy_o),
    .cipher_valid_o   (cipher_valid_o),
    .done_o           (done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic       sel;
    logic       en;
    logic       xdb;
    logic       xkb;
    logic       xke;
    logic       xee;
    logic       ecip;
    logic       etag;
    logic       busy;
    logic       cv;
    logic       done;
    logic       rdy;
    logic [3:0] round;
  } obs_t;

  typedef struct {
    int ad;
    int pt;
    int done_at;
  } vec_t;

  obs_t act;
  assign act = {select_o, enable_o,
                xor_data_begin_o, xor_key_begin_o,
                xor_key_end_o, xor_ext_end_o,
                enable_cipher_o, enable_tag_o,
                busy_o, cipher_valid_o, done_o,
                data_ready_o, round_o};

  int   n_cmp = 0;
  int   n_err = 0;
  int   cycles;
  int   done_g;
  logic cv_exp = 1'b0;

  function automatic obs_t z();
    obs_t o;
    o = '0;
    return o;
  endfunction

  task automatic check_int(input int got,
                           input int want,
                           input string nm);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  // One clock cycle: drive, compare, advance.
  task automatic cyc(input obs_t e_in,
                     input logic v,
                     input logic st,
                     input string nm);
    obs_t e;
    e = e_in;
    e.cv = cv_exp;
    data_valid_i = v;
    start_i = st;
    #1;
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %h want %h",
               nm, cycles, act, e);
    end
    if (act.done === 1'b1) done_g = cycles;
    cv_exp = e.ecip & ~reset_i;
    cycles++;
    @(negedge clock_i);
  endtask

  function automatic logic pick(input int mode,
                                input bit in_ad,
                                input int b,
                                input int tries);
    if (mode == 1) return $urandom_range(0, 2) != 0;
    if (mode == 2) return !(in_ad && b == 1 &&
                            tries < 5);
    return 1'b1;
  endfunction

  // Walk the spec schedule: 12 init rounds, 6 per AD
  // block, 6 per non-last PT block, 12 for last PT +
  // finalization, then one done cycle.
  task automatic run_op(input int ad,
                        input int pt,
                        input int mode,
                        input bit mid_start,
                        input bit abort,
                        output int done_at,
                        output int stalls);
    int   pte;
    int   tries;
    bit   last;
    obs_t e;
    logic v;
    pte = (pt == 0) ? 1 : pt;
    stalls = 0;
    cycles = 0;
    done_g = -1;
    ad_blocks_i = 4'(ad);
    pt_blocks_i = 4'(pt);
    cyc(z(), 1'b0, 1'b1, "idle_start");
    ad_blocks_i = 4'($urandom);
    pt_blocks_i = 4'($urandom);
    for (int r = 0; r < 12; r++) begin
      e = z();
      e.busy = 1; e.en = 1; e.round = 4'(r);
      e.sel = (r == 0);
      e.xke = (r == 11);
      e.xee = (r == 11 && ad == 0);
      cyc(e, 1'($urandom), 1'b0, "init");
    end
    for (int b = 0; b < ad; b++) begin
      tries = 0;
      do begin
        v = pick(mode, 1'b1, b, tries);
        if (tries >= 50) v = 1'b1;
        e = z();
        e.busy = 1; e.rdy = 1; e.round = 4'd6;
        e.en = v; e.xdb = v;
        cyc(e, v, 1'b0, "ad_handshake");
        if (!v) stalls++;
        tries++;
      end while (!v);
      for (int r = 7; r < 12; r++) begin
        e = z();
        e.busy = 1; e.en = 1; e.round = 4'(r);
        e.xee = (r == 11 && b == ad - 1);
        cyc(e, 1'($urandom),
            mid_start && r == 8, "ad_round");
      end
    end
    for (int b = 0; b < pte; b++) begin
      last = (b == pte - 1);
      tries = 0;
      do begin
        v = pick(mode, 1'b0, b, tries);
        if (tries >= 50) v = 1'b1;
        e = z();
        e.busy = 1; e.rdy = 1;
        e.round = last ? 4'd0 : 4'd6;
        e.en = v; e.xdb = v; e.ecip = v;
        e.xkb = v & last;
        cyc(e, v, 1'b0, "pt_handshake");
        if (!v) stalls++;
        tries++;
      end while (!v);
      if (!last) begin
        for (int r = 7; r < 12; r++) begin
          e = z();
          e.busy = 1; e.en = 1; e.round = 4'(r);
          cyc(e, 1'($urandom), 1'b0, "pt_round");
        end
      end
    end
    for (int r = 1; r < 12; r++) begin
      e = z();
      e.busy = 1; e.en = 1; e.round = 4'(r);
      e.xke = (r == 11); e.etag = (r == 11);
      if (abort && r == 4) begin
        reset_i = 1'b1;
        cyc(e, 1'b0, 1'b0, "final_reset");
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++)
          cyc(z(), 1'($urandom), 1'b0, "post_reset");
        done_at = done_g;
        return;
      end
      cyc(e, 1'($urandom), 1'b0, "final");
    end
    e = z();
    e.busy = 1; e.done = 1;
    cyc(e, 1'b1, 1'b0, "done");
    cyc(z(), 1'b1, 1'b0, "idle_after");
    done_at = done_g;
  endtask

  vec_t vecs[7];
  int   d;
  int   s;
  int   ra;
  int   rp;
  int   pe;

  initial begin
    vecs[0] = '{ad: 1,  pt: 1,  done_at: 31};
    vecs[1] = '{ad: 0,  pt: 2,  done_at: 31};
    vecs[2] = '{ad: 2,  pt: 1,  done_at: 37};
    vecs[3] = '{ad: 0,  pt: 1,  done_at: 25};
    vecs[4] = '{ad: 15, pt: 15, done_at: 199};
    vecs[5] = '{ad: 3,  pt: 0,  done_at: 43};
    vecs[6] = '{ad: 0,  pt: 15, done_at: 109};

    reset_i = 1'b1;
    start_i = 1'b0;
    data_valid_i = 1'b0;
    ad_blocks_i = 4'd0;
    pt_blocks_i = 4'd0;
    cycles = 0;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    cyc(z(), 1'b1, 1'b0, "reset_state");
    cyc(z(), 1'b0, 1'b0, "reset_state");

    // Reset wins over a coincident start.
    reset_i = 1'b1;
    cyc(z(), 1'b0, 1'b1, "rst_with_start");
    reset_i = 1'b0;
    cyc(z(), 1'b0, 1'b0, "rst_priority");

    foreach (vecs[i]) begin
      run_op(vecs[i].ad, vecs[i].pt, 0, 1'b0,
             1'b0, d, s);
      check_int(d, vecs[i].done_at, "latency_vec");
    end

    run_op(1, 1, 0, 1'b1, 1'b0, d, s);
    check_int(d, 31, "mid_start_latency");

    run_op(2, 1, 2, 1'b0, 1'b0, d, s);
    check_int(s, 5, "stall_count");
    check_int(d, 42, "stall_latency");

    run_op(1, 1, 0, 1'b0, 1'b1, d, s);
    check_int(d, -1, "abort_no_done");
    run_op(1, 1, 0, 1'b0, 1'b0, d, s);
    check_int(d, 31, "after_abort_latency");

    for (int k = 0; k < 25; k++) begin
      ra = $urandom_range(0, 4);
      rp = $urandom_range(0, 4);
      pe = (rp == 0) ? 1 : rp;
      run_op(ra, rp, 1, k[0], 1'b0, d, s);
      check_int(d, 12 + 6 * ra + 6 * (pe - 1)
                   + 13 + s, "rand_latency");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_ctrl.md
ASCON_CTRL -- requirements
Module: ascon_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous active-high reset: clock_i rising edge only; reset_i synchronous, active-high.
REQ-002 SHALL have ports: clock_i  in  1  system clock; reset_i  in  1  sync active-high reset.
REQ-003 SHALL have ports: start_i  in  1  begin encryption; ad_blocks_i  in  4  padded AD blocks (0..15); pt_blocks_i  in  4  padded PT blocks (1..15).
REQ-004 SHALL have ports: data_valid_i  in  1  upstream 64-bit block present; data_ready_o  out  1  block accepted when valid&ready.
REQ-005 SHALL have datapath-control outputs, each 1 bit: select_o, enable_o, xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_ext_end_o, enable_cipher_o, enable_tag_o; plus round_o  out  4  round index 0..11.
REQ-006 SHALL have status outputs, each 1 bit: busy_o, cipher_valid_o (ciphertext register updated last cycle), done_o (tag register valid).

Function
REQ-007 SHALL implement states IDLE, INIT, AD, PT, FINAL, DONE; one permutation round per enabled cycle.
REQ-008 IDLE: all outputs 0, round_o=0; start_i=1 latches ad_blocks_i/pt_blocks_i and moves to INIT with round 0; start_i is ignored outside IDLE.
REQ-009 INIT: round_o 0..11, enable_o=1 every cycle; select_o=1 only at round 0; xor_key_end_o=1 at round 11.
REQ-010 At INIT round 11, if latched ad_blocks=0, xor_ext_end_o SHALL also be 1 and the next state SHALL be PT; otherwise the next state SHALL be AD.
REQ-011 AD: round_o 6..11; at round 6, data_ready_o=1; if data_valid_i=0, enable_o=0 and state/round hold (stall); if 1, enable_o=1 and xor_data_begin_o=1 in that same cycle.
REQ-012 AD rounds 7..11 SHALL assert enable_o only; at round 11 of the last AD block, xor_ext_end_o=1 and the next state SHALL be PT; otherwise the block counter SHALL decrement and round_o SHALL return to 6.
REQ-013 PT non-last block: round_o 6..11 with the REQ-011 handshake; the handshake cycle additionally asserts enable_cipher_o=1.
REQ-014 PT last block: handshake cycle SHALL drive round_o=0, data_ready_o=1, and on valid: enable_o, xor_data_begin_o, xor_key_begin_o, enable_cipher_o all 1, then go to FINAL at round 1; on no valid, hold with enable_o=0.
REQ-015 FINAL: round_o 1..11, enable_o=1; at round 11, xor_key_end_o=1 and enable_tag_o=1; next state DONE.
REQ-016 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-017 cipher_valid_o SHALL be a registered one-cycle pulse in the cycle after each enable_cipher_o=1.
REQ-018 busy_o SHALL be 1 in every state except IDLE.
REQ-019 data_ready_o SHALL depend on state only; xor_data_begin_o, enable_o and enable_cipher_o in handshake cycles SHALL be combinational on data_valid_i (Mealy).
REQ-020 data_valid_i SHALL be ignored whenever data_ready_o=0.
REQ-021 Block counters SHALL be 4-bit, load latched values and never wrap; pt_blocks_i=0 SHALL be treated as 1.

Reset
REQ-022 reset_i=1 at a clock edge SHALL force IDLE, clear counters and cipher_valid_o/done_o, regardless of state (mid-operation included); all outputs read 0 in the following cycle.
REQ-023 reset_i SHALL take priority over start_i in the same cycle.

Structure
REQ-024 State enum type and constants PA_FIRST_ROUND=0, PB_FIRST_ROUND=6, LAST_ROUND=11 SHALL live in ascon_pack.
REQ-025 One sub-module, round_counter (4-bit loadable up-counter with load value and enable), SHALL be instantiated; the FSM and output decode stay in ascon_ctrl.

Verification
REQ-026 ad=1, pt=1, valid always 1: start at cycle 0 -> INIT 12 cycles, AD 6 cycles, PT/FINAL 12 cycles, done_o=1 at cycle 31, enable_tag_o exactly once.
REQ-027 ad=0, pt=2: INIT round 11 shows xor_key_end_o=xor_ext_end_o=1; no AD cycles; two enable_cipher_o pulses; cipher_valid_o two pulses.
REQ-028 ad=2, pt=1, data_valid_i low 5 cycles at second AD block -> round_o holds 6, enable_o=0 for 5 cycles, total latency grows by 5.
REQ-029 reset_i=1 during FINAL round 4 -> next cycle IDLE, busy_o=0, done_o never asserted; new start_i completes normally.
REQ-030 start_i pulsed during AD -> ignored; outputs and counts unchanged versus REQ-026 reference run.
